// File: rtl/axi_pkg.sv
// Shared AXI definitions: handshake FSM state encodings and
// the AXI burst-type and response codes.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_ASSERT = 2'b10
    } hs_state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/axi_read_channel_fsm_if.sv
// AR/R channel signals of one AXI4 read link.
// The master drives them and the slave observes them.
interface axi_read_channel_fsm_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;

    modport master (
        output axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        output axi_arvalid, axi_arready,
        output axi_rdata, axi_rresp, axi_rlast,
        output axi_rvalid, axi_rready
    );

    modport slave (
        input axi_araddr, axi_arlen, axi_arsize, axi_arburst,
        input axi_arvalid, axi_arready,
        input axi_rdata, axi_rresp, axi_rlast,
        input axi_rvalid, axi_rready
    );
endinterface

// File: rtl/axi_read_channel_fsm.sv
// AR and R channel handshake FSMs for one AXI4 read link with
// a single outstanding burst; generates rlast from a beat counter.
module axi_read_channel_fsm
    import axi_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic [AW-1:0] araddr_in,
    input  logic [7:0]    arlen_in,
    input  logic [2:0]    arsize_in,
    input  logic [1:0]    arburst_in,
    input  logic          arvalid_in,
    input  logic [DW-1:0] rdata_in,
    input  logic [1:0]    rresp_in,
    input  logic          rvalid_in,
    input  logic          rready_in,
    axi_read_channel_fsm_if.master bus
);

    hs_state_t  ar_state;
    hs_state_t  r_state;
    logic       r_active;
    logic [7:0] r_cnt;
    logic       ar_hs;
    logic       r_hs;
    logic       r_take;

    assign ar_hs  = bus.axi_arvalid & bus.axi_arready;
    assign r_hs   = bus.axi_rvalid & bus.axi_rready;
    assign r_take = r_active & rvalid_in;

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            ar_state        <= ST_WAIT;
            bus.axi_araddr  <= '0;
            bus.axi_arlen   <= '0;
            bus.axi_arsize  <= '0;
            bus.axi_arburst <= BURST_FIXED;
            bus.axi_arvalid <= 1'b0;
            bus.axi_arready <= 1'b1;
        end else begin
            unique case (ar_state)
                ST_WAIT: begin
                    bus.axi_arready <= !r_active;
                    if (arvalid_in) begin
                        bus.axi_araddr  <= araddr_in;
                        bus.axi_arlen   <= arlen_in;
                        bus.axi_arsize  <= arsize_in;
                        bus.axi_arburst <= arburst_in;
                        bus.axi_arvalid <= 1'b1;
                        ar_state <= r_active ? ST_ASSERT : ST_COMMIT;
                    end else begin
                        bus.axi_arvalid <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    bus.axi_arready <= 1'b0;
                    if (arvalid_in) begin
                        bus.axi_araddr  <= araddr_in;
                        bus.axi_arlen   <= arlen_in;
                        bus.axi_arsize  <= arsize_in;
                        bus.axi_arburst <= arburst_in;
                        bus.axi_arvalid <= 1'b1;
                        ar_state        <= ST_ASSERT;
                    end else begin
                        bus.axi_arvalid <= 1'b0;
                        ar_state        <= ST_WAIT;
                    end
                end
                ST_ASSERT: begin
                    if (!r_active) begin
                        bus.axi_arready <= 1'b1;
                        ar_state        <= ST_COMMIT;
                    end
                end
                default: ar_state <= ST_WAIT;
            endcase
        end
    end

    // WAIT and a non-final COMMIT share the same beat-accept path
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_state        <= ST_WAIT;
            bus.axi_rdata  <= '0;
            bus.axi_rresp  <= RESP_OKAY;
            bus.axi_rvalid <= 1'b0;
            bus.axi_rready <= 1'b0;
        end else if (r_state == ST_ASSERT) begin
            if (rready_in) begin
                bus.axi_rready <= 1'b1;
                r_state        <= ST_COMMIT;
            end
        end else if (r_state == ST_COMMIT && bus.axi_rlast) begin
            bus.axi_rvalid <= 1'b0;
            bus.axi_rready <= rready_in;
            r_state        <= ST_WAIT;
        end else if (r_take) begin
            bus.axi_rdata  <= rdata_in;
            bus.axi_rresp  <= rresp_in;
            bus.axi_rvalid <= 1'b1;
            bus.axi_rready <= rready_in;
            r_state        <= rready_in ? ST_COMMIT : ST_ASSERT;
        end else begin
            bus.axi_rvalid <= 1'b0;
            bus.axi_rready <= rready_in;
            r_state        <= ST_WAIT;
        end
    end

    // r_cnt holds the beats still to come after the current one
    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            r_active      <= 1'b0;
            r_cnt         <= '0;
            bus.axi_rlast <= 1'b0;
        end else if (ar_hs) begin
            r_active      <= 1'b1;
            r_cnt         <= bus.axi_arlen;
            bus.axi_rlast <= (bus.axi_arlen == 8'd0);
        end else if (r_hs) begin
            if (bus.axi_rlast) begin
                r_active      <= 1'b0;
                bus.axi_rlast <= 1'b0;
            end else begin
                r_cnt         <= r_cnt - 8'd1;
                bus.axi_rlast <= (r_cnt == 8'd1);
            end
        end
    end

endmodule

// File: tb/tb_axi_read_channel_fsm.sv
// Randomized bench for axi_read_channel_fsm with a
// transaction-level model of the AR/R protocol.
module tb_axi_read_channel_fsm;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr_in = '0;
    logic [7:0]  arlen_in = '0;
    logic [2:0]  arsize_in = '0;
    logic [1:0]  arburst_in = '0;
    logic        arvalid_in = 1'b0;
    logic [63:0] rdata_in = '0;
    logic [1:0]  rresp_in = '0;
    logic        rvalid_in = 1'b0;
    logic        rready_in = 1'b0;

    axi_read_channel_fsm_if #(.AW(32), .DW(64)) bus ();

    axi_read_channel_fsm #(.AW(32), .DW(64)) dut (
        .axi_aclk  (clk),
        .rst       (rst),
        .araddr_in (araddr_in),
        .arlen_in  (arlen_in),
        .arsize_in (arsize_in),
        .arburst_in(arburst_in),
        .arvalid_in(arvalid_in),
        .rdata_in  (rdata_in),
        .rresp_in  (rresp_in),
        .rvalid_in (rvalid_in),
        .rready_in (rready_in),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: requested ARs, outstanding burst, beat count
    logic [44:0] ar_q[$];
    logic [44:0] ar_exp;
    bit          outstanding = 0;
    int          exp_len = 0;
    int          beats = 0;
    int          bursts_done = 0;
    int          gap = 0;
    bit          prev_rvalid = 0, prev_rready = 0, prev_rlast = 0;
    logic [63:0] prev_rdata = '0;
    logic [1:0]  prev_rresp = '0;
    bit          off_rvalid = 0;
    logic [63:0] off_rdata = '0;
    logic [1:0]  off_rresp = '0;

    always @(negedge clk) begin
        if (rst) begin
            ar_q.delete();
            outstanding = 0;
            beats = 0;
            gap = 0;
            prev_rvalid = 0;
            prev_rready = 0;
        end else begin
            if (gap == 2) begin
                check("ar_reopen", bus.axi_arready, 1);
                gap = 0;
            end
            if (gap == 1) begin
                check("ar_gap", bus.axi_arready, 0);
                check("r_after_last", bus.axi_rvalid, 0);
                gap = 2;
            end
            if (outstanding && bus.axi_arvalid)
                check("ar_blocked", bus.axi_arready, 0);
            if (bus.axi_arvalid && bus.axi_arready) begin
                check("ar_single", outstanding, 0);
                if (ar_q.size() == 0) begin
                    check("ar_spurious", 1, 0);
                end else begin
                    ar_exp = ar_q.pop_front();
                    check("ar_payload",
                          {bus.axi_araddr, bus.axi_arlen,
                           bus.axi_arsize, bus.axi_arburst},
                          ar_exp);
                end
                outstanding = 1;
                exp_len = int'(bus.axi_arlen);
                beats = 0;
            end
            if (bus.axi_rvalid) begin
                if (!(prev_rvalid && !prev_rready)) begin
                    check("r_no_addr", outstanding, 1);
                    check("r_offered", off_rvalid, 1);
                    check("r_data", bus.axi_rdata, off_rdata);
                    check("r_resp", bus.axi_rresp, off_rresp);
                end else begin
                    check("r_hold_data", bus.axi_rdata, prev_rdata);
                    check("r_hold_last", bus.axi_rlast, prev_rlast);
                end
                if (bus.axi_rready) begin
                    check("r_last", bus.axi_rlast, beats == exp_len);
                    beats++;
                    if (beats == exp_len + 1) begin
                        outstanding = 0;
                        bursts_done++;
                        gap = 1;
                    end
                end
            end
            prev_rvalid = bus.axi_rvalid;
            prev_rready = bus.axi_rready;
            prev_rlast  = bus.axi_rlast;
            prev_rdata  = bus.axi_rdata;
            prev_rresp  = bus.axi_rresp;
        end
        off_rvalid = rvalid_in;
        off_rdata  = rdata_in;
        off_rresp  = rresp_in;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arvalid_in = 1'b0;
        rvalid_in = 1'b0;
        rready_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_arvalid", bus.axi_arvalid, 0);
        check("rst_arready", bus.axi_arready, 1);
        check("rst_rvalid", bus.axi_rvalid, 0);
        check("rst_rready", bus.axi_rready, 0);
        check("rst_rlast", bus.axi_rlast, 0);
        check("rst_rresp", bus.axi_rresp, 0);
        check("rst_araddr", bus.axi_araddr, 0);
        check("rst_arlen", bus.axi_arlen, 0);
        check("rst_rdata", bus.axi_rdata, 0);
        cyc();
        rst = 1'b0;
    endtask

    task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        while (ar_q.size() != 0 && n < 3000) begin
            cyc();
            n++;
        end
        if (n >= 3000) check("ar_wait_timeout", 0, 1);
        araddr_in  = addr;
        arlen_in   = len;
        arsize_in  = 3'($urandom_range(3));
        arburst_in = BURST_INCR;
        arvalid_in = 1'b1;
        ar_q.push_back({addr, len, arsize_in, arburst_in});
        cyc();
        arvalid_in = 1'b0;
    endtask

    task automatic drive_r(input int target, input int pv, input int pr);
        int n = 0;
        while (bursts_done < target && n < 3000) begin
            rvalid_in = ($urandom_range(99) < pv);
            rready_in = ($urandom_range(99) < pr);
            rdata_in  = {$urandom, $urandom};
            rresp_in  = 2'($urandom_range(3));
            cyc();
            n++;
        end
        check("burst_done", bursts_done >= target, 1);
    endtask

    task automatic drive_until_beats(input int b);
        int n = 0;
        while (beats < b && n < 200) begin
            rvalid_in = 1'b1;
            rready_in = 1'b1;
            rdata_in  = {$urandom, $urandom};
            cyc();
            n++;
        end
        check("beat_reach", beats >= b, 1);
    endtask

    initial begin
        do_reset();

        // single-beat burst
        issue_ar(32'h1000, 8'd0);
        drive_r(bursts_done + 1, 100, 100);

        // four beats, ready always high
        issue_ar(32'h1100, 8'd3);
        drive_r(bursts_done + 1, 100, 100);

        // four beats with a two-cycle ready stall
        issue_ar(32'h1200, 8'd3);
        drive_until_beats(1);
        rready_in = 1'b0;
        repeat (2) cyc();
        drive_r(bursts_done + 1, 100, 100);

        // second AR arrives mid-burst and must wait
        issue_ar(32'h3000, 8'd3);
        drive_until_beats(1);
        rvalid_in = 1'b0;
        issue_ar(32'h2000, 8'd1);
        @(negedge clk);
        @(negedge clk);
        check("pend_arvalid", bus.axi_arvalid, 1);
        check("pend_arready", bus.axi_arready, 0);
        check("pend_araddr", bus.axi_araddr, 32'h2000);
        cyc();
        drive_r(bursts_done + 2, 70, 70);

        // data with no address is ignored
        do_reset();
        rvalid_in = 1'b1;
        rready_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rdata_in = {$urandom, $urandom};
            @(negedge clk);
            check("no_addr_rvalid", bus.axi_rvalid, 0);
        end
        cyc();

        // reset mid-burst, then a clean two-beat burst
        issue_ar(32'h5000, 8'd7);
        drive_until_beats(2);
        do_reset();
        issue_ar(32'h4000, 8'd1);
        drive_r(bursts_done + 1, 100, 100);

        // random bursts under random valid/ready pressure
        for (int i = 0; i < 20; i++) begin
            issue_ar($urandom, 8'($urandom_range(15)));
            drive_r(bursts_done + 1, $urandom_range(30, 100),
                    $urandom_range(30, 100));
        end

        repeat (4) cyc();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
